// File: rtl/dds_mode_fader.sv
// N-channel waveform selector for the DDS DAC path: mode changes fade the gain to zero,
// swap the routed channel at zero gain, then fade back up so the DAC never sees a step.
module dds_mode_fader #(
    parameter int N_CH       = 8,
    parameter int SEL_W      = 3,
    parameter int IN_W       = 16,
    parameter int OUT_W      = 14,
    parameter int GAIN_W     = 8,
    parameter int GAIN_STEP  = 16,
    parameter bit OFFSET_BIN = 1'b1
) (
    input  logic                   clk_100M,
    input  logic                   rst,
    input  logic [SEL_W-1:0]       mode,
    input  logic [N_CH*IN_W-1:0]   sig_in,
    output logic [OUT_W-1:0]       sig_out,
    output logic [SEL_W-1:0]       mode_active,
    output logic                   busy
);

    localparam int PROD_W = IN_W + GAIN_W + 1;

    localparam logic [GAIN_W:0]  G_FULL   = {1'b1, {GAIN_W{1'b0}}};
    localparam logic [GAIN_W:0]  G_STEP   = (GAIN_W + 1)'(GAIN_STEP);
    localparam logic [OUT_W-1:0] MIDSCALE = {OFFSET_BIN, {(OUT_W - 1){1'b0}}};

    typedef enum logic [1:0] {
        RUN,
        FADE_OUT,
        SWAP,
        FADE_IN
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [GAIN_W:0]    r_gain;
    logic [GAIN_W:0]    w_gain_nxt;
    logic [GAIN_W:0]    w_gain_up;
    logic [GAIN_W:0]    w_gain_dn;
    logic [SEL_W-1:0]   r_mode_active;
    logic [SEL_W-1:0]   w_mode_active_nxt;

    logic [IN_W-1:0]    w_sel;
    logic [IN_W-1:0]    r_sel;
    logic [GAIN_W:0]    r_gain_s1;
    logic [PROD_W-1:0]  w_sel_ext;
    logic [PROD_W-1:0]  w_gain_ext;
    logic [PROD_W-1:0]  w_prod;
    logic [OUT_W-1:0]   r_sig_out;
    logic               w_unused;

    // Clamped gain steps; the gain never wraps past zero or full scale.
    assign w_gain_up = (r_gain >= G_FULL - G_STEP) ? G_FULL : r_gain + G_STEP;
    assign w_gain_dn = (r_gain <= G_STEP) ? '0 : r_gain - G_STEP;

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        w_state_nxt       = r_state;
        w_gain_nxt        = r_gain;
        w_mode_active_nxt = r_mode_active;
        case (r_state)
            SWAP: begin
                w_mode_active_nxt = mode;
                w_state_nxt       = FADE_IN;
            end
            RUN, FADE_OUT, FADE_IN: begin
                if (mode != r_mode_active) begin
                    w_gain_nxt  = w_gain_dn;
                    w_state_nxt = (w_gain_dn == '0) ? SWAP : FADE_OUT;
                end else begin
                    w_gain_nxt  = w_gain_up;
                    w_state_nxt = (w_gain_up == G_FULL) ? RUN : FADE_IN;
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_100M) begin
        if (rst) begin
            r_state       <= FADE_IN;
            r_gain        <= '0;
            r_mode_active <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_gain        <= w_gain_nxt;
            r_mode_active <= w_mode_active_nxt;
        end
    end

    // Channel mux; an out-of-range mode_active matches no channel and routes zero.
    always_comb begin
        w_sel = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (r_mode_active == SEL_W'(k)) begin
                w_sel = sig_in[k*IN_W +: IN_W];
            end
        end
    end

    // Sign-extended sample times zero-extended gain; the low PROD_W bits are the signed product.
    assign w_sel_ext  = {{(GAIN_W + 1){r_sel[IN_W-1]}}, r_sel};
    assign w_gain_ext = {{IN_W{1'b0}}, r_gain_s1};
    assign w_prod     = w_sel_ext * w_gain_ext;
    assign w_unused   = ^{w_prod[PROD_W-1], w_prod[GAIN_W+IN_W-OUT_W-1:0]};

    // NOTE: pipeline registers are reset too, so the first words after reset are midscale, not stale data.
    always_ff @(posedge clk_100M) begin
        if (rst) begin
            r_sel     <= '0;
            r_gain_s1 <= '0;
            r_sig_out <= MIDSCALE;
        end else begin
            r_sel     <= w_sel;
            r_gain_s1 <= r_gain;
            r_sig_out <= w_prod[IN_W+GAIN_W-1 -: OUT_W] ^ MIDSCALE;
        end
    end

    assign sig_out     = r_sig_out;
    assign mode_active = r_mode_active;
    assign busy        = (r_state != RUN);

endmodule

// File: tb/tb_dds_mode_fader.sv
// Bench for dds_mode_fader: an 8-channel and a 7-channel instance share stimulus and are
// compared every cycle against a cycle-level model of the fade rules, plus literal spot values.
module tb_dds_mode_fader;

    logic         clk_100M = 1'b0;
    logic         rst      = 1'b1;
    logic [2:0]   mode     = 3'd0;
    logic [127:0] sig_in   = '0;
    logic [111:0] sig_in7;

    logic [13:0]  sig_out8, sig_out7;
    logic [2:0]   ma8, ma7;
    logic         busy8, busy7;

    int checks = 0;
    int errors = 0;

    assign sig_in7 = sig_in[111:0];

    always #5 clk_100M = ~clk_100M;

    dds_mode_fader #(.N_CH(8)) dut8 (
        .clk_100M   (clk_100M),
        .rst        (rst),
        .mode       (mode),
        .sig_in     (sig_in),
        .sig_out    (sig_out8),
        .mode_active(ma8),
        .busy       (busy8)
    );

    dds_mode_fader #(.N_CH(7)) dut7 (
        .clk_100M   (clk_100M),
        .rst        (rst),
        .mode       (mode),
        .sig_in     (sig_in7),
        .sig_out    (sig_out7),
        .mode_active(ma7),
        .busy       (busy7)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_gain;
    int          m_ma;
    bit          m_swap;
    bit          model_valid = 1'b0;
    int          st_gain;
    logic [15:0] st_s [2];
    logic [13:0] exp_out [2];

    function automatic logic [15:0] chan(input int ma, input int n_ch);
        if (ma < n_ch) return sig_in[ma*16 +: 16];
        return 16'h0000;
    endfunction

    // Output word = top 14 bits of floor(sample * gain / 256), offset-binary.
    function automatic logic [13:0] scale(input logic [15:0] s, input int g);
        int v;
        int q;
        v = int'($signed(s)) * g;
        q = v / 1024;
        if (v < 0 && q * 1024 != v) q = q - 1;
        return 14'((q & 32'h3FFF) ^ 32'h2000);
    endfunction

    always @(posedge clk_100M) begin
        if (rst) begin
            m_gain      = 0;
            m_ma        = 0;
            m_swap      = 1'b0;
            st_gain     = 0;
            st_s[0]     = '0;
            st_s[1]     = '0;
            exp_out[0]  = 14'h2000;
            exp_out[1]  = 14'h2000;
            model_valid = 1'b1;
        end else begin
            exp_out[0] = scale(st_s[0], st_gain);
            exp_out[1] = scale(st_s[1], st_gain);
            st_gain    = m_gain;
            st_s[0]    = chan(m_ma, 8);
            st_s[1]    = chan(m_ma, 7);
            if (m_swap) begin
                m_ma   = int'(mode);
                m_swap = 1'b0;
            end else if (int'(mode) != m_ma) begin
                m_gain = (m_gain > 16) ? m_gain - 16 : 0;
                if (m_gain == 0) m_swap = 1'b1;
            end else begin
                m_gain = (m_gain < 240) ? m_gain + 16 : 256;
            end
        end
    end

    always @(negedge clk_100M) begin
        if (model_valid) begin
            check("out8",  32'(sig_out8), 32'(exp_out[0]));
            check("out7",  32'(sig_out7), 32'(exp_out[1]));
            check("ma8",   32'(ma8),      32'(m_ma));
            check("ma7",   32'(ma7),      32'(m_ma));
            check("busy8", 32'(busy8),    32'(m_gain != 256));
            check("busy7", 32'(busy7),    32'(m_gain != 256));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk_100M);
        #2;
    endtask

    task automatic wait_idle(input int max_cycles, output int n);
        n = 0;
        do begin
            tick(1);
            n++;
        end while (busy8 && n < max_cycles);
    endtask

    logic [15:0] sweep [10];

    initial begin
        int n;
        logic [15:0] v;
        sweep = '{16'h8000, 16'h8001, 16'hFFFF, 16'h0000, 16'h0003,
                  16'h0004, 16'h7FFF, 16'h4000, 16'hC000, 16'h5555};
        for (int k = 0; k < 8; k++) sig_in[k*16 +: 16] = 16'(k * 16'h1111);
        sig_in[0*16 +: 16] = 16'h4000;
        sig_in[3*16 +: 16] = 16'hC000;
        sig_in[7*16 +: 16] = 16'h1234;

        // Reset holds midscale, channel 0, busy.
        tick(3);
        check("rst_out8", 32'(sig_out8), 32'h2000);
        check("rst_out7", 32'(sig_out7), 32'h2000);
        check("rst_ma",   32'(ma8),      32'h0);
        check("rst_busy", 32'(busy8),    32'h1);

        rst = 1'b0;
        wait_idle(100, n);
        check("fadein_len", 32'(n), 32'd16);
        tick(3);
        check("ch0_full", 32'(sig_out8), 32'h3000);

        // Full switch 0 -> 3.
        mode = 3'd3;
        tick(16);
        check("swap_busy", 32'(busy8), 32'h1);
        check("swap_ma_old", 32'(ma8), 32'h0);
        tick(1);
        check("swap_ma_new", 32'(ma8), 32'h3);
        wait_idle(100, n);
        check("fadein_after_swap", 32'(n), 32'd16);
        tick(3);
        check("ch3_full", 32'(sig_out8), 32'h1000);

        // Aborted switch: 5 steps down, then 5 back up with no swap.
        mode = 3'd0;
        tick(5);
        mode = 3'd3;
        wait_idle(100, n);
        check("abort_len", 32'(n), 32'd5);
        check("abort_ma", 32'(ma8), 32'h3);
        tick(3);
        check("abort_out", 32'(sig_out8), 32'h1000);

        // Channel 7: valid on 8-channel build, invalid on 7-channel build.
        mode = 3'd7;
        wait_idle(100, n);
        check("switch7_len", 32'(n), 32'd33);
        check("ma7_dut8", 32'(ma8), 32'h7);
        check("ma7_dut7", 32'(ma7), 32'h7);
        tick(3);
        check("invalid_mid", 32'(sig_out7), 32'h2000);
        check("ch7_full",    32'(sig_out8), 32'h248D);

        // Reset in the middle of a fade-out.
        mode = 3'd0;
        tick(8);
        check("midfade_busy", 32'(busy8), 32'h1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("rst_mid_ma",   32'(ma8),      32'h0);
        check("rst_mid_out",  32'(sig_out8), 32'h2000);
        check("rst_mid_busy", 32'(busy8),    32'h1);
        wait_idle(100, n);
        check("rst_mid_fadein", 32'(n), 32'd16);
        tick(2);

        // Full-gain sweep on ch0: output is the top 14 input bits, offset-binary.
        for (int i = 0; i <= 10; i++) begin
            if (i < 10) sig_in[15:0] = sweep[i];
            tick(1);
            if (i >= 1) begin
                v = sweep[i-1];
                check("sweep", 32'(sig_out8), 32'({~v[15], v[14:2]}));
            end
        end

        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
